// File: rtl/snake_head_ctrl_pkg.sv
// snake_head_ctrl_pkg: shared heading/state encodings and default grid size
package snake_head_ctrl_pkg;
  localparam int DEF_GRID_W = 32;
  localparam int DEF_GRID_H = 24;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;
endpackage

// File: rtl/slow_tick_det.sv
// slow_tick_det: one-CLOCK tick on each rising edge of the game-rate SLOW_CLOCK
module slow_tick_det (
  input  logic CLOCK,
  input  logic RESET,
  input  logic SLOW_CLOCK,
  output logic TICK
);
  logic prev;
  always_ff @(posedge CLOCK) prev <= RESET ? 1'b0 : SLOW_CLOCK;
  assign TICK = SLOW_CLOCK & ~prev;
endmodule

// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: game FSM and head position/heading update on each slow tick
module snake_head_ctrl
  import snake_head_ctrl_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int START_X = 16,
  parameter int START_Y = 12,
  parameter int WRAP = 1,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          SLOW_CLOCK,
  input  logic          E,
  input  logic          L,
  input  logic          R,
  input  logic          COLLIDE,
  output logic [XW-1:0] HEAD_X,
  output logic [YW-1:0] HEAD_Y,
  output logic [1:0]    DIR,
  output logic          STEP,
  output logic          RUNNING,
  output logic          DEAD
);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  state_t state, state_n;
  dir_t dir, dir_n;
  logic [1:0] turn;
  logic [XW-1:0] x, x_n, mx;
  logic [YW-1:0] y, y_n, my;
  logic tick, wall, step_n;
  slow_tick_det u_tick (.CLOCK(CLOCK), .RESET(RESET), .SLOW_CLOCK(SLOW_CLOCK), .TICK(tick));
  // Turn is applied before the move, so the move uses the new heading
  always_comb begin
    turn = (L & ~R) ? dir - 2'd1 : (R & ~L) ? dir + 2'd1 : dir;
    wall = (turn == DIR_RIGHT && x == XMAX) || (turn == DIR_LEFT && x == '0) ||
           (turn == DIR_DOWN && y == YMAX) || (turn == DIR_UP && y == '0);
    mx = (turn == DIR_RIGHT) ? ((x == XMAX) ? '0 : x + XW'(1)) :
         (turn == DIR_LEFT) ? ((x == '0) ? XMAX : x - XW'(1)) : x;
    my = (turn == DIR_DOWN) ? ((y == YMAX) ? '0 : y + YW'(1)) :
         (turn == DIR_UP) ? ((y == '0) ? YMAX : y - YW'(1)) : y;
  end
  always_comb begin
    state_n = state;
    dir_n = dir;
    x_n = x;
    y_n = y;
    step_n = 1'b0;
    if (state == ST_RUN && COLLIDE) state_n = ST_DEAD;
    else if (tick) begin
      if (state == ST_IDLE && E) state_n = ST_RUN;
      else if (state == ST_DEAD && E) begin
        state_n = ST_IDLE;
        x_n = XW'(START_X);
        y_n = YW'(START_Y);
        dir_n = DIR_RIGHT;
      end else if (state == ST_RUN && WRAP == 0 && wall) state_n = ST_DEAD;
      else if (state == ST_RUN) begin
        dir_n = dir_t'(turn);
        x_n = mx;
        y_n = my;
        step_n = 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= ST_IDLE;
      dir <= DIR_RIGHT;
      x <= XW'(START_X);
      y <= YW'(START_Y);
      STEP <= 1'b0;
    end else begin
      state <= state_n;
      dir <= dir_n;
      x <= x_n;
      y <= y_n;
      STEP <= step_n;
    end
  end
  assign HEAD_X = x;
  assign HEAD_Y = y;
  assign DIR = dir;
  assign RUNNING = state == ST_RUN;
  assign DEAD = state == ST_DEAD;
endmodule

// File: tb/tb_snake_head_ctrl.sv
// tb_snake_head_ctrl: scoreboard bench over three configurations sharing one stimulus
module tb_snake_head_ctrl;
  typedef struct {int cyc; int d; int x; int y; int dir; int s; int r; int k; string n;} exp_t;
  logic CLOCK = 1'b0, RESET = 1'b1, SLOW_CLOCK = 1'b0, E = 1'b0, L = 1'b0, R = 1'b0, COLLIDE = 1'b0;
  logic [4:0] hx [3];
  logic [4:0] hy [3];
  logic [1:0] dr [3];
  logic st [3];
  logic rn [3];
  logic dd [3];
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  snake_head_ctrl u0 (.CLOCK(CLOCK), .RESET(RESET), .SLOW_CLOCK(SLOW_CLOCK), .E(E), .L(L), .R(R),
    .COLLIDE(COLLIDE), .HEAD_X(hx[0]), .HEAD_Y(hy[0]), .DIR(dr[0]), .STEP(st[0]), .RUNNING(rn[0]), .DEAD(dd[0]));
  snake_head_ctrl #(.START_X(30), .START_Y(0)) u1 (.CLOCK(CLOCK), .RESET(RESET), .SLOW_CLOCK(SLOW_CLOCK),
    .E(E), .L(L), .R(R), .COLLIDE(COLLIDE), .HEAD_X(hx[1]), .HEAD_Y(hy[1]), .DIR(dr[1]), .STEP(st[1]),
    .RUNNING(rn[1]), .DEAD(dd[1]));
  snake_head_ctrl #(.START_X(30), .START_Y(5), .WRAP(0)) u2 (.CLOCK(CLOCK), .RESET(RESET),
    .SLOW_CLOCK(SLOW_CLOCK), .E(E), .L(L), .R(R), .COLLIDE(COLLIDE), .HEAD_X(hx[2]), .HEAD_Y(hy[2]),
    .DIR(dr[2]), .STEP(st[2]), .RUNNING(rn[2]), .DEAD(dd[2]));
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;
  always @(negedge CLOCK) begin
    exp_t e;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].cyc == cyc) begin
        e = q[i];
        checks++;
        if (int'(hx[e.d]) != e.x || int'(hy[e.d]) != e.y || int'(dr[e.d]) != e.dir ||
            int'(st[e.d]) != e.s || int'(rn[e.d]) != e.r || int'(dd[e.d]) != e.k) begin
          errors++;
          $display("FAIL %s dut%0d got x=%0d y=%0d dir=%0d step=%0d run=%0d dead=%0d need x=%0d y=%0d dir=%0d step=%0d run=%0d dead=%0d",
            e.n, e.d, hx[e.d], hy[e.d], dr[e.d], st[e.d], rn[e.d], dd[e.d], e.x, e.y, e.dir, e.s, e.r, e.k);
        end
        q.delete(i);
      end
  end
  task automatic push(input int dc, input int d, input int x, input int y, input int dir,
                      input int s, input int r, input int k, input string n);
    q.push_back('{cyc + dc, d, x, y, dir, s, r, k, n});
  endtask
  // expect values in the cycle after the edge, then the same values with STEP low one cycle later
  task automatic chk2(input int d, input int x, input int y, input int dir, input int r,
                      input int k, input int s, input string n);
    push(1, d, x, y, dir, s, r, k, n);
    push(2, d, x, y, dir, 0, r, k, {n, "_after"});
  endtask
  task automatic go(input logic e, input logic l, input logic r, input logic c, input logic rs);
    @(negedge CLOCK);
    {E, L, R, COLLIDE, RESET} = '0;
    SLOW_CLOCK = 1'b0;
    repeat (2) @(negedge CLOCK);
    SLOW_CLOCK = 1'b1;
    {E, L, R, COLLIDE, RESET} = {e, l, r, c, rs};
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge CLOCK);
    push(1, 0, 16, 12, 1, 0, 0, 0, "reset");
    push(1, 1, 30, 0, 1, 0, 0, 0, "reset");
    push(1, 2, 30, 5, 1, 0, 0, 0, "reset");
    @(negedge CLOCK);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go(0, 0, 0, 0, 0);
      chk2(0, 16, 12, 1, 0, 0, 0, "idle_noE");
      chk2(2, 30, 5, 1, 0, 0, 0, "idle_noE");
    end
    go(1, 0, 0, 0, 0);
    chk2(0, 16, 12, 1, 1, 0, 0, "start");
    chk2(1, 30, 0, 1, 1, 0, 0, "start");
    chk2(2, 30, 5, 1, 1, 0, 0, "start");
    go(0, 0, 0, 0, 0);
    chk2(0, 17, 12, 1, 1, 0, 1, "move1");
    chk2(1, 31, 0, 1, 1, 0, 1, "move1");
    chk2(2, 31, 5, 1, 1, 0, 1, "move1");
    go(0, 0, 0, 0, 0);
    chk2(0, 18, 12, 1, 1, 0, 1, "move2");
    chk2(1, 0, 0, 1, 1, 0, 1, "wrap_x");
    chk2(2, 31, 5, 1, 0, 1, 0, "wall");
    go(0, 1, 0, 0, 0);
    chk2(0, 18, 11, 0, 1, 0, 1, "left");
    chk2(1, 0, 23, 0, 1, 0, 1, "wrap_y");
    chk2(2, 31, 5, 1, 0, 1, 0, "dead_hold");
    go(0, 1, 1, 0, 0);
    chk2(0, 18, 10, 0, 1, 0, 1, "both");
    chk2(1, 0, 22, 0, 1, 0, 1, "both");
    go(1, 0, 0, 0, 0);
    chk2(0, 18, 9, 0, 1, 0, 1, "e_in_run");
    chk2(2, 30, 5, 1, 0, 0, 0, "restart");
    go(1, 0, 0, 0, 0);
    chk2(0, 18, 8, 0, 1, 0, 1, "e_in_run2");
    chk2(2, 30, 5, 1, 1, 0, 0, "rerun");
    go(0, 0, 1, 0, 0);
    chk2(0, 19, 8, 1, 1, 0, 1, "right");
    chk2(1, 1, 20, 1, 1, 0, 1, "right");
    chk2(2, 30, 6, 2, 1, 0, 1, "right");
    @(negedge CLOCK);
    {E, L, R} = '0;
    @(negedge CLOCK);
    COLLIDE = 1'b1;
    push(1, 0, 19, 8, 1, 0, 0, 1, "collide");
    push(1, 1, 1, 20, 1, 0, 0, 1, "collide");
    push(1, 2, 30, 6, 2, 0, 0, 1, "collide");
    @(negedge CLOCK);
    COLLIDE = 1'b0;
    go(0, 0, 0, 0, 0);
    chk2(0, 19, 8, 1, 0, 1, 0, "dead_nomove");
    chk2(1, 1, 20, 1, 0, 1, 0, "dead_nomove");
    go(1, 0, 0, 0, 0);
    chk2(0, 16, 12, 1, 0, 0, 0, "reload");
    chk2(1, 30, 0, 1, 0, 0, 0, "reload");
    go(1, 0, 0, 0, 0);
    chk2(0, 16, 12, 1, 1, 0, 0, "run_again");
    go(0, 0, 0, 1, 0);
    chk2(0, 16, 12, 1, 0, 1, 0, "collide_on_tick");
    chk2(1, 30, 0, 1, 0, 1, 0, "collide_on_tick");
    go(1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0);
    chk2(0, 16, 12, 1, 1, 0, 0, "run3");
    go(0, 0, 0, 0, 1);
    chk2(0, 16, 12, 1, 0, 0, 0, "reset_on_tick");
    chk2(2, 30, 5, 1, 0, 0, 0, "reset_on_tick");
    @(negedge CLOCK);
    {E, L, R, COLLIDE, RESET} = '0;
    repeat (4) @(negedge CLOCK);
    if (q.size() != 0) begin
      $display("FAIL pending got %0d unchecked need 0", q.size());
      errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
